// File: rtl/div_err_monitor.sv
// rtl/div_err_monitor.sv - exact-vs-approximate 16/8 divider error statistics (option: DIV_ERR_REM_CHECK_EN)
module div_err_monitor #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_n,
   input  logic [7:0]       in_d,
   input  logic [7:0]       in_q,
   input  logic [7:0]       in_r,
   input  logic             clear,
   output logic             err_valid,
   output logic [7:0]       err_abs,
   output logic [ACC_W-1:0] sse,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] skip_cnt,
   output logic [7:0]       max_err,
   output logic [CNT_W-1:0] rem_mismatch_cnt
);

   localparam int SUM_W = ((ACC_W > 16) ? ACC_W : 16) + 1;

   typedef enum logic [1:0] {IDLE, DIV, ACC, SKIP} state_t;

   state_t           state, state_nxt;
   logic             accept, reject;
   logic [7:0]       p, n_lo, d_lat, q_lat, quot;
   logic [2:0]       iter;
   logic [8:0]       p_sh;
   logic             ge;
   logic [7:0]       p_nxt;
   logic [7:0]       e;
   logic [15:0]      sq;
   logic [SUM_W-1:0] sse_sum;
   logic             sse_ovf;

   assign in_ready = (state == IDLE) && !clear;
   assign accept   = in_valid && in_ready;
   assign reject   = (in_d == 8'd0) || (in_n[15:8] >= in_d);

   // The partial remainder never reaches d, so 8 stored bits suffice between iterations.
   assign p_sh  = {p, n_lo[7]};
   assign ge    = p_sh >= {1'b0, d_lat};
   assign p_nxt = ge ? 8'(p_sh - {1'b0, d_lat}) : p_sh[7:0];

   assign e       = (quot >= q_lat) ? (quot - q_lat) : (q_lat - quot);
   assign sq      = {8'd0, e} * {8'd0, e};
   assign sse_sum = SUM_W'(sse) + SUM_W'(sq);
   assign sse_ovf = |sse_sum[SUM_W-1:ACC_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = reject ? SKIP : DIV;
         DIV:     if (iter == 3'd7) state_nxt = ACC;
         ACC:     state_nxt = IDLE;
         SKIP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p         <= '0;
         n_lo      <= '0;
         d_lat     <= '0;
         q_lat     <= '0;
         quot      <= '0;
         iter      <= '0;
         err_valid <= 1'b0;
         err_abs   <= '0;
         sse       <= '0;
         count     <= '0;
         skip_cnt  <= '0;
         max_err   <= '0;
      end else begin
         err_valid <= 1'b0;
         if (clear) begin
            err_abs  <= '0;
            sse      <= '0;
            count    <= '0;
            skip_cnt <= '0;
            max_err  <= '0;
         end else begin
            case (state)
               IDLE: if (accept) begin
                  p     <= in_n[15:8];
                  n_lo  <= in_n[7:0];
                  d_lat <= in_d;
                  q_lat <= in_q;
                  quot  <= '0;
                  iter  <= '0;
               end
               DIV: begin
                  p    <= p_nxt;
                  n_lo <= {n_lo[6:0], 1'b0};
                  quot <= {quot[6:0], ge};
                  iter <= iter + 3'd1;
               end
               ACC: begin
                  err_abs   <= e;
                  err_valid <= 1'b1;
                  sse       <= sse_ovf ? '1 : sse_sum[ACC_W-1:0];
                  if (count != '1) count <= count + CNT_W'(1);
                  if (e > max_err) max_err <= e;
               end
               SKIP: if (skip_cnt != '1) skip_cnt <= skip_cnt + CNT_W'(1);
               default: ;
            endcase
         end
      end
   end

`ifdef DIV_ERR_REM_CHECK_EN
   logic [7:0] r_lat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lat            <= '0;
         rem_mismatch_cnt <= '0;
      end else if (clear) begin
         rem_mismatch_cnt <= '0;
      end else begin
         if (accept) r_lat <= in_r;
         if (state == ACC && p != r_lat && rem_mismatch_cnt != '1)
            rem_mismatch_cnt <= rem_mismatch_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_r;
   assign unused_r         = ^in_r;
   assign rem_mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_div_err_monitor.sv
// tb/tb_div_err_monitor.sv - self-checking bench for div_err_monitor
module tb_div_err_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] in_n = '0;
   logic [7:0]  in_d = '0, in_q = '0, in_r = '0;

   logic        in_ready, err_valid;
   logic [7:0]  err_abs, max_err;
   logic [39:0] sse;
   logic [23:0] count, skip_cnt, rem_mismatch_cnt;

   logic        s_ready, s_err_valid;
   logic [7:0]  s_err_abs, s_max_err;
   logic [7:0]  s_sse;
   logic [23:0] s_count, s_skip_cnt, s_mis;

   div_err_monitor #(.ACC_W(40), .CNT_W(24)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_n(in_n), .in_d(in_d), .in_q(in_q), .in_r(in_r), .clear(clear),
      .err_valid(err_valid), .err_abs(err_abs), .sse(sse), .count(count),
      .skip_cnt(skip_cnt), .max_err(max_err), .rem_mismatch_cnt(rem_mismatch_cnt));

   div_err_monitor #(.ACC_W(8), .CNT_W(24)) dut_small (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_ready),
      .in_n(in_n), .in_d(in_d), .in_q(in_q), .in_r(in_r), .clear(clear),
      .err_valid(s_err_valid), .err_abs(s_err_abs), .sse(s_sse), .count(s_count),
      .skip_cnt(s_skip_cnt), .max_err(s_max_err), .rem_mismatch_cnt(s_mis));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   longint m_sse, m_count, m_skip, m_max, m_mis;

   typedef struct {
      logic [15:0] n;
      logic [7:0]  d, q, r;
      int          err;   // -1: expected rejection
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_sse = 0; m_count = 0; m_skip = 0; m_max = 0; m_mis = 0;
   endtask

   function automatic longint exp_mis();
`ifdef DIV_ERR_REM_CHECK_EN
      return m_mis;
`else
      return 0;
`endif
   endfunction

   function automatic longint small_sse();
      return (m_sse > 255) ? 255 : m_sse;
   endfunction

   task automatic check_stats(input string tag);
      chk({tag, "_sse"}, sse, m_sse);
      chk({tag, "_sse_small"}, s_sse, small_sse());
      chk({tag, "_count"}, count, m_count);
      chk({tag, "_skip_cnt"}, skip_cnt, m_skip);
      chk({tag, "_max_err"}, max_err, m_max);
      chk({tag, "_rem_mismatch"}, rem_mismatch_cnt, exp_mis());
   endtask

   // Starts and ends at a falling edge with the DUT idle.
   task automatic run_sample(input logic [15:0] n, input logic [7:0] d, input logic [7:0] q,
                             input logic [7:0] r, input int table_err);
      bit rej, busy;
      int qe, re, e, exp_e;
      rej = (d == 0) || ((n >> 8) >= d);
      chk("ready_before_accept", in_ready, 1);
      in_valid = 1'b1; in_n = n; in_d = d; in_q = q; in_r = r;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_n = 16'($urandom); in_d = 8'($urandom); in_q = 8'($urandom); in_r = 8'($urandom);
      @(negedge clk);
      chk("busy_after_accept", {in_ready, err_valid}, 0);
      if (rej) begin
         m_skip++;
         @(negedge clk);
         chk("skip_err_valid", err_valid, 0);
         chk("skip_ready_again", in_ready, 1);
         check_stats("skip");
      end else begin
         qe = int'(n) / int'(d);
         re = int'(n) % int'(d);
         e = (qe > int'(q)) ? qe - int'(q) : int'(q) - qe;
         exp_e = (table_err >= 0) ? table_err : e;
         m_sse += longint'(e) * e;
         m_count++;
         if (e > m_max) m_max = e;
         if (re != int'(r)) m_mis++;
         busy = 1'b0;
         repeat (8) begin
            @(negedge clk);
            if (in_ready || err_valid) busy = 1'b1;
         end
         chk("busy_during_div", busy, 0);
         @(negedge clk);
         chk("acc_err_valid", err_valid, 1);
         chk("acc_err_abs", err_abs, exp_e);
         chk("acc_ready", in_ready, 1);
         check_stats("acc");
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      #1;
      chk("ready_low_during_clear", in_ready, 0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      model_reset();
      @(negedge clk);
      chk("clear_err_abs", err_abs, 0);
      chk("clear_ready", in_ready, 1);
      check_stats("clear");
   endtask

   initial begin
      bit ev;
      int mode;
      logic [7:0] d, q, r;
      logic [15:0] n;

      tbl[0] = '{16'd100,  8'd7,    8'd14,  8'd2,  0};
      tbl[1] = '{16'd100,  8'd7,    8'd12,  8'd5,  2};
      tbl[2] = '{16'd255,  8'd16,   8'd20,  8'd15, 5};
      tbl[3] = '{16'd0,    8'd0,    8'd0,   8'd0,  -1};
      tbl[4] = '{16'h0800, 8'h08,   8'd0,   8'd0,  -1};
      tbl[5] = '{16'h00FF, 8'd1,    8'd239, 8'd0,  16};
      tbl[6] = '{16'h00FF, 8'd1,    8'd239, 8'd0,  16};
      tbl[7] = '{16'hFEFF, 8'hFF,   8'd0,   8'd254, 255};
      tbl[8] = '{16'hFF00, 8'hFF,   8'd0,   8'd0,  -1};

      model_reset();
      #2 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_ready", in_ready, 1);
      chk("reset_err_valid", err_valid, 0);
      chk("reset_err_abs", err_abs, 0);
      check_stats("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         if (i == 1) do_clear();
         run_sample(tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].r, tbl[i].err);
         if (i == 2) begin
            chk("pair_sse", sse, 29);
            chk("pair_max_err", max_err, 5);
            chk("pair_count", count, 2);
         end
         if (i == 6) chk("small_sse_saturated", s_sse, 255);
      end

      // Asynchronous reset two iterations into DIV.
      in_valid = 1'b1; in_n = 16'd1000; in_d = 8'd9; in_q = 8'd0; in_r = 8'd0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("async_rst_ready", in_ready, 1);
      chk("async_rst_err_valid", err_valid, 0);
      chk("async_rst_err_abs", err_abs, 0);
      check_stats("async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_sample(16'd1000, 8'd9, 8'd100, 8'd1, 11);

      // Clear sampled at the fourth DIV edge aborts the sample.
      in_valid = 1'b1; in_n = 16'd100; in_d = 8'd7; in_q = 8'd0; in_r = 8'd2;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(negedge clk);
      clear = 1'b1;
      #1;
      chk("mid_div_clear_ready", in_ready, 0);
      @(posedge clk);
      #1 clear = 1'b0;
      model_reset();
      @(negedge clk);
      chk("mid_div_clear_ready_after", in_ready, 1);
      chk("mid_div_clear_err_abs", err_abs, 0);
      check_stats("mid_div_clear");
      ev = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (err_valid) ev = 1'b1;
      end
      chk("mid_div_clear_no_pulse", ev, 0);

      for (int i = 0; i < 60; i++) begin
         mode = int'($urandom_range(0, 3));
         d = 8'($urandom_range(0, 255));
         if (mode == 0 || d == 0) n = 16'($urandom);
         else n = {8'($urandom_range(0, int'(d) - 1)), 8'($urandom)};
         q = 8'($urandom);
         if (mode == 2 && d != 0) q = 8'((int'(n) / int'(d)) + int'($urandom_range(0, 3)));
         r = (mode >= 2 && d != 0) ? 8'(int'(n) % int'(d)) : 8'($urandom);
         run_sample(n, d, q, r, -2);
         if ($urandom_range(0, 2) == 0) begin
            ev = 1'b0;
            repeat ($urandom_range(1, 3)) begin
               @(negedge clk);
               if (err_valid) ev = 1'b1;
            end
            chk("idle_gap_no_pulse", ev, 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
